// File: rtl/instr_buffer_pkg.sv
// Shared constants and helpers for the instruction buffer: zero-extend opcodes,
// the default pointer type, and the opcode decode used to pick sign/zero extension.
package instr_buffer_pkg;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;

    localparam int DEF_DEPTH = 4;

    // One extra bit beyond the address so full and empty can be told apart.
    typedef logic [$clog2(DEF_DEPTH):0] ptr_t;

    function automatic logic is_zext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
    endfunction

endpackage

// File: rtl/instr_buffer_mem.sv
// DEPTH x WIDTH register array for the instruction buffer: one synchronous
// write port, one asynchronous read port, storage is not reset.
module instr_buffer_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_buffer.sv
// Instruction FIFO feeding the sign extender; presents the head's immediate,
// opcode and extend select. Optional same-cycle bypass: INSTR_BUFFER_BYPASS_EN.
module instr_buffer
    import instr_buffer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int IMM_W = 16,
    parameter int OP_W  = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IMM_W-1:0]         out_imm,
    output logic [OP_W-1:0]          out_op,
    output logic                     out_sext,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;

    logic [PW-1:0]    wptr, rptr;
    logic             full, empty;
    logic             push, pop, pass;
    logic             head_valid;
    logic [WIDTH-1:0] rdata, head_word;
    logic [OP_W-1:0]  head_op;
    logic             unused_mid;

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);

`ifdef INSTR_BUFFER_BYPASS_EN
    // An empty buffer forwards in_instr directly; if it is consumed the same
    // cycle it never touches storage.
    assign pass       = empty && in_valid && out_ready;
    assign head_valid = !empty || in_valid;
    assign head_word  = empty ? in_instr : rdata;
`else
    assign pass       = 1'b0;
    assign head_valid = !empty;
    assign head_word  = rdata;
`endif

    // Handshake: a transfer happens on a side only when its valid and ready are
    // both high at the rising edge; ready never depends on valid of the same side.
    assign in_ready  = !full;
    assign push      = in_valid && in_ready && !pass && !flush;
    assign pop       = !empty && out_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    instr_buffer_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wptr[AW-1:0]),
        .wdata (in_instr),
        .raddr (rptr[AW-1:0]),
        .rdata (rdata)
    );

    assign head_op    = head_word[WIDTH-1 -: OP_W];
    assign out_valid  = head_valid;
    assign out_imm    = head_valid ? head_word[IMM_W-1:0] : '0;
    assign out_op     = head_valid ? head_op : '0;
    assign out_sext   = head_valid && !is_zext(head_op);
    assign count      = wptr - rptr;

    // Fields between the immediate and the opcode are not used by this stage.
    assign unused_mid = ^head_word[WIDTH-OP_W-1:IMM_W];

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model. Honours INSTR_BUFFER_BYPASS_EN.
module tb_instr_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_imm;
    logic [5:0]  out_op;
    logic        out_sext;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    instr_buffer #(
        .WIDTH (32),
        .DEPTH (DEPTH),
        .IMM_W (16),
        .OP_W  (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_op    (out_op),
        .out_sext  (out_sext),
        .count     (count)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

`ifdef INSTR_BUFFER_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Reference model: the buffer is simply an ordered list of at most DEPTH words.
    function automatic logic exp_valid();
        return (exp_q.size() > 0) || (BYPASS && in_valid);
    endfunction

    function automatic logic [31:0] exp_word();
        if (exp_q.size() > 0) return exp_q[0];
        if (BYPASS && in_valid) return in_instr;
        return 32'h0;
    endfunction

    function automatic logic exp_sext(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        return !(op == 6'h0C || op == 6'h0D || op == 6'h0E);
    endfunction

    // Driver tasks: drive just after the falling edge, settle, then let checks sample.
    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        in_valid  = v;
        in_instr  = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    task automatic tick();
        int sz;
        @(posedge clk);
        sz = exp_q.size();
        if (rst || flush) begin
            exp_q.delete();
        end else if (!(BYPASS && sz == 0 && in_valid && out_ready)) begin
            if (out_ready && sz > 0) void'(exp_q.pop_front());
            if (in_valid && sz < DEPTH) exp_q.push_back(in_instr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_imm !== 16'h0) begin n_fail++; $display("FAIL reset_out_imm: got %h want 0", out_imm); end
        n_checks++; if (out_op !== 6'h0) begin n_fail++; $display("FAIL reset_out_op: got %h want 0", out_op); end
        n_checks++; if (out_sext !== 1'b0) begin n_fail++; $display("FAIL reset_out_sext: got %b want 0", out_sext); end
    endtask

    task automatic test_basic_push();
        drive(1'b1, 32'h2008FFFF, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b want 1", out_valid); end
        n_checks++; if (out_imm !== 16'hFFFF) begin n_fail++; $display("FAIL basic_out_imm: got %h want ffff", out_imm); end
        n_checks++; if (out_op !== 6'h08) begin n_fail++; $display("FAIL basic_out_op: got %h want 08", out_op); end
        n_checks++; if (out_sext !== 1'b1) begin n_fail++; $display("FAIL basic_out_sext: got %b want 1", out_sext); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL basic_count: got %0d want 1", count); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL basic_drain_count: got %0d want 0", count); end
    endtask

    task automatic test_zext();
        drive(1'b1, 32'h3421ABCD, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (out_op !== 6'h0D) begin n_fail++; $display("FAIL zext_out_op: got %h want 0d", out_op); end
        n_checks++; if (out_imm !== 16'hABCD) begin n_fail++; $display("FAIL zext_out_imm: got %h want abcd", out_imm); end
        n_checks++; if (out_sext !== 1'b0) begin n_fail++; $display("FAIL zext_out_sext: got %b want 0", out_sext); end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_fill_full();
        logic [31:0] w [4];
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            drive(1'b1, w[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", in_ready); end
        drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_ignored_count: got %0d want 4", count); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++;
            if (out_imm !== w[i][15:0] || out_op !== w[i][31:26] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_pop_order[%0d]: got v=%b op=%h imm=%h want v=1 op=%h imm=%h",
                         i, out_valid, out_op, out_imm, w[i][31:26], w[i][15:0]);
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty_valid: got %b want 0", out_valid); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL fill_empty_count: got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [12];
        for (int i = 0; i < 12; i++) seq[i] = 32'h04000001 * i + 32'h00001000;
        drive(1'b1, seq[0], 1'b0, 1'b0); tick();
        drive(1'b1, seq[1], 1'b0, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, seq[i+2], 1'b1, 1'b0);
            n_checks++;
            if (count !== 3'd2 || out_imm !== seq[i][15:0] || out_op !== seq[i][31:26]) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got cnt=%0d op=%h imm=%h want cnt=2 op=%h imm=%h",
                         i, count, out_op, out_imm, seq[i][31:26], seq[i][15:0]);
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_final_count: got %0d want 2", count); end
        n_checks++; if (out_imm !== seq[10][15:0]) begin n_fail++; $display("FAIL b2b_final_head: got %h want %h", out_imm, seq[10][15:0]); end
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h12345678, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_imm !== 16'h0) begin n_fail++; $display("FAIL flush_out_imm: got %h want 0", out_imm); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_bypass();
        drive(1'b1, 32'h3C01FFFF, 1'b1, 1'b0);
        n_checks++; if (out_valid !== BYPASS) begin n_fail++; $display("FAIL bypass_out_valid: got %b want %b", out_valid, BYPASS); end
        n_checks++;
        if (out_imm !== (BYPASS ? 16'hFFFF : 16'h0000)) begin
            n_fail++; $display("FAIL bypass_out_imm: got %h want %h", out_imm, BYPASS ? 16'hFFFF : 16'h0000);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (count !== (BYPASS ? 3'd0 : 3'd1)) begin
            n_fail++; $display("FAIL bypass_count: got %0d want %0d", count, BYPASS ? 0 : 1);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic test_rst_midstream();
        drive(1'b1, 32'h3821FFFF, 1'b0, 1'b0); tick();
        drive(1'b1, 32'h8C220004, 1'b0, 1'b0); tick();
        rst = 1'b1;
        drive(1'b1, 32'h11111111, 1'b1, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_op !== 6'h0 || out_sext !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs: got op=%h sext=%b want 0/0", out_op, out_sext); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic        v;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
            w = exp_word();
            v = exp_valid();
            n_checks++;
            if (count !== 3'(exp_q.size()) || out_valid !== v || in_ready !== (exp_q.size() < DEPTH)) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got cnt=%0d v=%b rdy=%b want cnt=%0d v=%b rdy=%b",
                         cyc, count, out_valid, in_ready, exp_q.size(), v, exp_q.size() < DEPTH);
            end
            n_checks++;
            if (out_imm !== (v ? w[15:0] : 16'h0) || out_op !== (v ? w[31:26] : 6'h0) ||
                out_sext !== (v && exp_sext(w))) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: got op=%h imm=%h sext=%b want op=%h imm=%h sext=%b",
                         cyc, out_op, out_imm, out_sext, v ? w[31:26] : 6'h0, v ? w[15:0] : 16'h0,
                         v && exp_sext(w));
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_push();
        test_zext();
        test_fill_full();
        test_back_to_back();
        test_flush();
        test_bypass();
        test_rst_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
